// File: rtl/i2s_slave_receiver.sv
// I2S / left-justified slave receiver.
// Oversamples an externally clocked serial audio bus and pushes each channel word,
// MSB-aligned and tagged with its channel, into a downstream write FIFO.
module i2s_slave_receiver #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_enable,
  input  logic [3:0]            cfg_byte_sz,
  input  logic                  cfg_ljust,
  input  logic                  cfg_edge,
  input  logic                  err_clr,
  input  logic                  i2s_sclk,
  input  logic                  i2s_lrck,
  input  logic                  i2s_sdi,
  input  logic                  f_full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_chan,
  output logic                  overflow,
  output logic                  frame_err
);

  typedef enum logic [2:0] {IDLE, SYNC, DELAY, SHIFT, PAD} state_t;

  state_t      state_reg;
  logic        sclk_meta, sclk_sync, sclk_hist;
  logic        lrck_meta, lrck_sync;
  logic        sdi_meta, sdi_sync;
  logic        prev_lrck_reg, prev_valid_reg;
  logic        ljust_reg, edge_reg, chan_reg;
  logic [4:0]  last_reg, cnt_reg;
  logic [31:0] shift_reg;

  logic        edge_sel, strobe, boundary, word_done;
  logic [31:0] word_next, start_shift;
  logic [4:0]  start_cnt;
  state_t      start_state;

  // Index of the last bit of a word for a given byte count; 0 or >4 means 4 bytes.
  function automatic logic [4:0] last_bit(input logic [3:0] bsz);
    case (bsz)
      4'd1:    last_bit = 5'd7;
      4'd2:    last_bit = 5'd15;
      4'd3:    last_bit = 5'd23;
      default: last_bit = 5'd31;
    endcase
  endfunction

  // Two-stage synchronisers for the pad inputs, plus a history stage on sclk for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_hist <= 1'b0;
      lrck_meta <= 1'b0;
      lrck_sync <= 1'b0;
      sdi_meta  <= 1'b0;
      sdi_sync  <= 1'b0;
    end else begin
      sclk_meta <= i2s_sclk;
      sclk_sync <= sclk_meta;
      sclk_hist <= sclk_sync;
      lrck_meta <= i2s_lrck;
      lrck_sync <= lrck_meta;
      sdi_meta  <= i2s_sdi;
      sdi_sync  <= sdi_meta;
    end
  end

  // Strobe, word-boundary detect and the first-bit setup shared by every word start.
  always_comb begin
    // In IDLE the latched edge is stale, so lrck tracking follows the live setting.
    edge_sel  = (state_reg == IDLE) ? cfg_edge : edge_reg;
    strobe    = edge_sel ? (~sclk_sync & sclk_hist) : (sclk_sync & ~sclk_hist);
    boundary  = strobe & prev_valid_reg & (lrck_sync ^ prev_lrck_reg);
    word_done = (cnt_reg == last_reg);
    word_next = shift_reg;
    word_next[5'd31 - cnt_reg] = sdi_sync;
    // Left-justified: the boundary strobe already carries the MSB.
    // I2S: the boundary strobe carries the previous slot's last bit, so the MSB comes next.
    start_state = ljust_reg ? SHIFT : DELAY;
    start_shift = ljust_reg ? {sdi_sync, 31'b0} : 32'b0;
    start_cnt   = ljust_reg ? 5'd1 : 5'd0;
  end

  // Receive FSM: framing, bit capture, FIFO push and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      prev_lrck_reg  <= 1'b0;
      prev_valid_reg <= 1'b0;
      ljust_reg      <= 1'b0;
      edge_reg       <= 1'b0;
      chan_reg       <= 1'b0;
      last_reg       <= 5'd31;
      cnt_reg        <= 5'd0;
      shift_reg      <= 32'b0;
      wr_en          <= 1'b0;
      wr_data        <= '0;
      wr_chan        <= 1'b0;
      overflow       <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      // Clear first so that a set event later in this block takes priority.
      if (err_clr) begin
        overflow  <= 1'b0;
        frame_err <= 1'b0;
      end
      // lrck history runs in every state so SYNC never sees a stale level as a boundary.
      if (strobe) begin
        prev_lrck_reg  <= lrck_sync;
        prev_valid_reg <= 1'b1;
      end
      if (state_reg != IDLE && !cfg_enable) begin
        state_reg <= IDLE;
        cnt_reg   <= 5'd0;
        shift_reg <= 32'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (cfg_enable) begin
              ljust_reg <= cfg_ljust;
              edge_reg  <= cfg_edge;
              last_reg  <= last_bit(cfg_byte_sz);
              cnt_reg   <= 5'd0;
              state_reg <= SYNC;
            end
          end
          SYNC, PAD: begin
            if (boundary) begin
              state_reg <= start_state;
              shift_reg <= start_shift;
              cnt_reg   <= start_cnt;
              chan_reg  <= lrck_sync;
            end
          end
          DELAY: begin
            if (strobe) begin
              if (boundary) begin
                // lrck flipped again before any data bit: restart the delay on the new channel.
                frame_err <= 1'b1;
                chan_reg  <= lrck_sync;
              end else begin
                shift_reg <= {sdi_sync, 31'b0};
                cnt_reg   <= 5'd1;
                state_reg <= SHIFT;
              end
            end
          end
          SHIFT: begin
            if (strobe) begin
              // In I2S mode the last bit of a full-slot word legitimately lands on the boundary.
              if (word_done && !(boundary && ljust_reg)) begin
                if (f_full) begin
                  overflow <= 1'b1;
                end else begin
                  wr_en   <= 1'b1;
                  wr_data <= word_next;
                  wr_chan <= chan_reg;
                end
                if (boundary) begin
                  state_reg <= start_state;
                  shift_reg <= start_shift;
                  cnt_reg   <= start_cnt;
                  chan_reg  <= lrck_sync;
                end else begin
                  state_reg <= PAD;
                  cnt_reg   <= 5'd0;
                end
              end else if (boundary) begin
                // Short word: drop it and let this boundary open the next word.
                frame_err <= 1'b1;
                state_reg <= start_state;
                shift_reg <= start_shift;
                cnt_reg   <= start_cnt;
                chan_reg  <= lrck_sync;
              end else begin
                shift_reg <= word_next;
                cnt_reg   <= cnt_reg + 5'd1;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_slave_receiver.sv
// Directed bench for i2s_slave_receiver: drives a slow I2S bus and checks the FIFO pushes.
module tb_i2s_slave_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [3:0]  cfg_byte_sz = 4'd4;
  logic        cfg_ljust = 1'b0;
  logic        cfg_edge = 1'b0;
  logic        err_clr = 1'b0;
  logic        i2s_sclk = 1'b0;
  logic        i2s_lrck = 1'b0;
  logic        i2s_sdi = 1'b0;
  logic        f_full = 1'b0;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_chan;
  logic        overflow;
  logic        frame_err;

  int          n_checks = 0;
  int          n_err = 0;
  logic        carry = 1'b0;
  logic [32:0] pushes[$];

  i2s_slave_receiver #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_byte_sz(cfg_byte_sz),
    .cfg_ljust(cfg_ljust), .cfg_edge(cfg_edge), .err_clr(err_clr),
    .i2s_sclk(i2s_sclk), .i2s_lrck(i2s_lrck), .i2s_sdi(i2s_sdi), .f_full(f_full),
    .wr_en(wr_en), .wr_data(wr_data), .wr_chan(wr_chan),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Record every FIFO write as {chan, data}.
  always @(negedge clk) begin
    if (wr_en) pushes.push_back({wr_chan, wr_data});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_count(input string tag, input int n);
    chk(tag, 64'(pushes.size()), 64'(n));
  endtask

  task automatic expect_word(input string tag, input logic [31:0] d, input logic c);
    logic [32:0] w;
    w = (pushes.size() > 0) ? pushes.pop_front() : '1;
    chk(tag, 64'(w), 64'({c, d}));
  endtask

  // One bus bit: data changes mid-low, rising edge after 4 clk, falling edge 8 clk later.
  task automatic send_bit(input logic lr, input logic d);
    i2s_lrck = lr;
    i2s_sdi  = d;
    repeat (4) @(negedge clk);
    i2s_sclk = 1'b1;
    repeat (8) @(negedge clk);
    i2s_sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // One channel slot of 'slot' bits carrying an n-bit word; I2S mode delays by one bit.
  task automatic send_slot(input logic lr, input logic [31:0] word, input int n,
                           input int slot, input logic lj, input logic pad);
    logic d;
    for (int j = 0; j < slot; j++) begin
      if (lj) d = (j < n) ? word[n-1-j] : pad;
      else if (j == 0) d = carry;
      else d = ((j - 1) < n) ? word[n-j] : pad;
      send_bit(lr, d);
    end
    if (!lj) carry = (n == slot) ? word[0] : pad;
  endtask

  // Return to IDLE, load a new configuration and settle lrck high before enabling.
  task automatic start(input logic [3:0] bsz, input logic lj, input logic ed);
    cfg_enable = 1'b0;
    repeat (3) @(negedge clk);
    cfg_byte_sz = bsz;
    cfg_ljust   = lj;
    cfg_edge    = ed;
    carry       = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    cfg_enable = 1'b1;
    repeat (2) @(negedge clk);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    pushes.delete();
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_wr_chan", 64'(wr_chan), 64'd0);
    chk("rst_flags", 64'({overflow, frame_err}), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: I2S, 16-bit words in 16-bit slots, back to back
    start(4'd2, 1'b0, 1'b0);
    send_slot(1'b0, 32'h0000A55A, 16, 16, 1'b0, 1'b0);
    send_slot(1'b1, 32'h00001234, 16, 16, 1'b0, 1'b0);
    send_bit(1'b0, carry);
    repeat (10) @(negedge clk);
    expect_count("t1_count", 2);
    expect_word("t1_left", 32'hA55A0000, 1'b0);
    expect_word("t1_right", 32'h12340000, 1'b1);
    chk("t1_frame_err", 64'(frame_err), 64'd0);

    // 2: left-justified 32-bit words
    start(4'd4, 1'b1, 1'b0);
    send_slot(1'b0, 32'hDEADBEEF, 32, 32, 1'b1, 1'b0);
    send_slot(1'b1, 32'h01234567, 32, 32, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    expect_count("t2_count", 2);
    expect_word("t2_left", 32'hDEADBEEF, 1'b0);
    expect_word("t2_right", 32'h01234567, 1'b1);
    chk("t2_frame_err", 64'(frame_err), 64'd0);

    // 3: I2S, 8-bit words in 32-bit slots padded with ones, sampled on falling sclk
    start(4'd1, 1'b0, 1'b1);
    send_slot(1'b0, 32'h000000C3, 8, 32, 1'b0, 1'b1);
    send_slot(1'b1, 32'h0000003C, 8, 32, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    expect_count("t3_count", 2);
    expect_word("t3_left", 32'hC3000000, 1'b0);
    expect_word("t3_right", 32'h3C000000, 1'b1);

    // 4: lrck toggles after 20 of 32 bits
    start(4'd4, 1'b1, 1'b0);
    send_slot(1'b0, 32'hFFFFFFFF, 32, 20, 1'b1, 1'b0);
    send_slot(1'b1, 32'h01234567, 32, 32, 1'b1, 1'b0);
    send_slot(1'b0, 32'hAABBCCDD, 32, 32, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("t4_frame_err", 64'(frame_err), 64'd1);
    expect_count("t4_count", 2);
    expect_word("t4_right", 32'h01234567, 1'b1);
    expect_word("t4_left", 32'hAABBCCDD, 1'b0);
    pulse_err_clr();
    chk("t4_frame_err_clr", 64'(frame_err), 64'd0);

    // 5: FIFO full during the left push
    start(4'd4, 1'b1, 1'b0);
    f_full = 1'b1;
    send_slot(1'b0, 32'h55555555, 32, 32, 1'b1, 1'b0);
    f_full = 1'b0;
    send_slot(1'b1, 32'h89ABCDEF, 32, 32, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("t5_overflow", 64'(overflow), 64'd1);
    chk("t5_frame_err", 64'(frame_err), 64'd0);
    expect_count("t5_count", 1);
    expect_word("t5_right", 32'h89ABCDEF, 1'b1);
    pulse_err_clr();
    chk("t5_overflow_clr", 64'(overflow), 64'd0);

    // 6a: reset in the middle of a word
    start(4'd2, 1'b1, 1'b0);
    send_slot(1'b0, 32'h00001111, 16, 8, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_outputs", 64'({wr_en, wr_chan, overflow, frame_err}), 64'd0);
    chk("t6_rst_wr_data", 64'(wr_data), 64'd0);
    rst = 1'b0;
    send_slot(1'b0, 32'h00001111, 8, 8, 1'b1, 1'b0);
    send_slot(1'b1, 32'h0000BEEF, 16, 16, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    expect_count("t6_rst_count", 1);
    expect_word("t6_rst_word", 32'hBEEF0000, 1'b1);

    // 6b: enable dropped in the middle of a word
    send_slot(1'b0, 32'h00001111, 16, 8, 1'b1, 1'b0);
    cfg_enable = 1'b0;
    repeat (2) @(negedge clk);
    cfg_enable = 1'b1;
    send_slot(1'b0, 32'h00001111, 8, 8, 1'b1, 1'b0);
    send_slot(1'b1, 32'h00004321, 16, 16, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    expect_count("t6_en_count", 1);
    expect_word("t6_en_word", 32'h43210000, 1'b1);
    chk("t6_flags", 64'({overflow, frame_err}), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
